instr_decode: RTL and testbench
===============================

INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 The block SHALL have these ports: clk  input  1  single clock; all state updates on posedge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 flush  input  1  squash the instruction currently presented by fetch (taken branch/jump).
REQ-004 OPcode  input  5 / ALUop  input  3 / Rs1, Rs2, Rd  input  5 each / Imm  input  16 / Address  input  27: fetch-register fields.
REQ-005 wb_en  input  1 / wb_rd  input  5 / wb_data  input  32: writeback port.
REQ-006 ex_mem_read  input  1 / ex_rd  input  5: a load currently in execute, and its destination.
REQ-007 stall  output  1: combinational; when 1, fetch holds its PC and fetch register.
REQ-008 d_valid, d_reg_write, d_mem_read, d_mem_write, d_branch_eq, d_branch_ne, d_jump, d_jump_reg, d_illegal  output  1 each: registered control.
REQ-009 d_opcode  output  5 / d_aluop  output  3 / d_rs1, d_rs2, d_rd  output  5 / d_rs1_val, d_rs2_val, d_imm  output  32 / d_address  output  27: registered datapath.
REQ-010 stall_count  output  16: saturating count of stall cycles.

Function
REQ-011 Opcode map: 00000 NOP; 00001 R-ALU; 00010 I-ALU; 00011 LOAD; 00100 STORE; 00101 BEQ; 00110 BNE; 00111 JUMP; 01000 JR; all others are illegal.
REQ-012 Controls:
- R/I-ALU and LOAD: d_reg_write=1.
- LOAD: d_mem_read=1.
- STORE: d_mem_write=1.
- BEQ: d_branch_eq=1. BNE: d_branch_ne=1.
- JUMP: d_jump=1. JR: d_jump_reg=1.
- Illegal: all controls 0 and d_illegal=1, with d_valid=1.
REQ-013 Register file: 32 x 32 bits. Register 0 reads 0 and ignores writes. A write occurs at posedge when wb_en=1 and wb_rd!=0.
REQ-014 Same-cycle bypass: a read of register r, with r!=0, wb_en=1 and wb_rd=r, SHALL return wb_data.
REQ-015 Rs1 is used by R-ALU, I-ALU, LOAD, STORE, BEQ, BNE and JR. Rs2 is used by R-ALU, STORE, BEQ and BNE.
REQ-016 stall SHALL be 1 if and only if all of the following hold:
- rst=0 and flush=0;
- ex_mem_read=1 and ex_rd!=0;
- ex_rd equals a used Rs1 or a used Rs2.
REQ-017 Immediate extension: zero-extend Imm when OPcode=I-ALU and ALUop[2]=1; sign-extend in all other cases.
REQ-018 Latency: one cycle. Fields presented at edge N appear on the d_* outputs after edge N.
REQ-019 Bubble: at a posedge with flush=1 or stall=1:
- d_valid and all control outputs SHALL be set to 0;
- the datapath outputs SHALL be set to 0.
REQ-020 Flush priority: flush has priority over stall. With both conditions true, stall=0 and a bubble is inserted.
REQ-021 A load-use stall SHALL last exactly one cycle when ex_* advances normally. The block SHALL re-evaluate stall every cycle with no internal stall state.
REQ-022 stall_count SHALL increment at each posedge where stall=1 and SHALL hold at 16'hFFFF.
REQ-023 A writeback coincident with a stall SHALL still commit to the register file.

Reset
REQ-024 At a posedge with rst=1:
- all d_* outputs and stall_count SHALL be set to 0;
- all 32 registers SHALL be cleared to 0.
REQ-025 During a cycle with rst=1, stall SHALL be 0 and a writeback SHALL be ignored.
REQ-026 Asserting rst mid-stall SHALL discard the stall; the first post-reset cycle decodes the current fetch fields normally.

Verification
REQ-027 Scenario: wb_en=1, wb_rd=5, wb_data=32'hDEADBEEF, with the same cycle presenting R-ALU Rs1=5, Rs2=0 -> next cycle d_rs1_val=DEADBEEF, d_rs2_val=0, d_reg_write=1.
REQ-028 Scenario: I-ALU with ALUop=3'b100 and Imm=16'h8001 -> d_imm=32'h00008001. LOAD with Imm=16'h8001 -> d_imm=32'hFFFF8001 and d_mem_read=1.
REQ-029 Scenario: ex_mem_read=1, ex_rd=7, with STORE Rs2=7 -> stall=1 for one cycle, then a bubble with d_valid=0 and stall_count=1. With ex_mem_read=0 the next cycle, the STORE issues with d_valid=1.
REQ-030 Scenario: ex_mem_read=1, ex_rd=7, with JUMP -> stall=0. With flush=1 and a hazard both present -> stall=0, bubble output, stall_count unchanged.
REQ-031 Scenario: wb_en=1, wb_rd=0, wb_data=5 -> a later read of register 0 returns 0. OPcode=5'b11111 -> d_illegal=1, d_reg_write=0.
REQ-032 Scenario: rst=1 pulsed after several writes -> d_* outputs=0, stall_count=0, and reads of registers 1-31 return 0.

Source files
------------

// File: rtl/instr_decode_if.sv
// Fetch-to-decode bus: fetch fields, writeback and execute-stage load info in,
// hazard stall and registered decode results out.
interface instr_decode_if;
  logic        flush;
  logic [4:0]  OPcode;
  logic [2:0]  ALUop;
  logic [4:0]  Rs1;
  logic [4:0]  Rs2;
  logic [4:0]  Rd;
  logic [15:0] Imm;
  logic [26:0] Address;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        stall;
  logic        d_valid;
  logic        d_reg_write;
  logic        d_mem_read;
  logic        d_mem_write;
  logic        d_branch_eq;
  logic        d_branch_ne;
  logic        d_jump;
  logic        d_jump_reg;
  logic        d_illegal;
  logic [4:0]  d_opcode;
  logic [2:0]  d_aluop;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic [4:0]  d_rd;
  logic [31:0] d_rs1_val;
  logic [31:0] d_rs2_val;
  logic [31:0] d_imm;
  logic [26:0] d_address;
  logic [15:0] stall_count;

  modport master (
    output flush, OPcode, ALUop, Rs1, Rs2, Rd, Imm, Address,
           wb_en, wb_rd, wb_data, ex_mem_read, ex_rd,
    input  stall, d_valid, d_reg_write, d_mem_read, d_mem_write, d_branch_eq,
           d_branch_ne, d_jump, d_jump_reg, d_illegal, d_opcode, d_aluop,
           d_rs1, d_rs2, d_rd, d_rs1_val, d_rs2_val, d_imm, d_address, stall_count
  );

  modport slave (
    input  flush, OPcode, ALUop, Rs1, Rs2, Rd, Imm, Address,
           wb_en, wb_rd, wb_data, ex_mem_read, ex_rd,
    output stall, d_valid, d_reg_write, d_mem_read, d_mem_write, d_branch_eq,
           d_branch_ne, d_jump, d_jump_reg, d_illegal, d_opcode, d_aluop,
           d_rs1, d_rs2, d_rd, d_rs1_val, d_rs2_val, d_imm, d_address, stall_count
  );
endinterface

// File: rtl/instr_decode.sv
// Decode stage: control decode, 32x32 register file with writeback bypass,
// load-use hazard detection and a one-cycle registered decode output.
module instr_decode (
  input logic           clk,
  input logic           rst,
  instr_decode_if.slave bus
);
  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_RALU  = 5'd1;
  localparam logic [4:0] OP_IALU  = 5'd2;
  localparam logic [4:0] OP_LOAD  = 5'd3;
  localparam logic [4:0] OP_STORE = 5'd4;
  localparam logic [4:0] OP_BEQ   = 5'd5;
  localparam logic [4:0] OP_BNE   = 5'd6;
  localparam logic [4:0] OP_JUMP  = 5'd7;
  localparam logic [4:0] OP_JR    = 5'd8;

  logic [31:0] rf_reg [32];
  logic        use_rs1, use_rs2;
  logic        reg_write, mem_read, mem_write, branch_eq, branch_ne;
  logic        jump, jump_reg, illegal;
  logic [31:0] rs1_val, rs2_val, imm_ext;
  logic        hazard, stall, bubble;

  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch_eq = 1'b0;
    branch_ne = 1'b0;
    jump      = 1'b0;
    jump_reg  = 1'b0;
    illegal   = 1'b0;
    case (bus.OPcode)
      OP_NOP:   begin end
      OP_RALU:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; reg_write = 1'b1; end
      OP_IALU:  begin use_rs1 = 1'b1; reg_write = 1'b1; end
      OP_LOAD:  begin use_rs1 = 1'b1; reg_write = 1'b1; mem_read = 1'b1; end
      OP_STORE: begin use_rs1 = 1'b1; use_rs2 = 1'b1; mem_write = 1'b1; end
      OP_BEQ:   begin use_rs1 = 1'b1; use_rs2 = 1'b1; branch_eq = 1'b1; end
      OP_BNE:   begin use_rs1 = 1'b1; use_rs2 = 1'b1; branch_ne = 1'b1; end
      OP_JUMP:  begin jump = 1'b1; end
      OP_JR:    begin use_rs1 = 1'b1; jump_reg = 1'b1; end
      default:  begin illegal = 1'b1; end
    endcase
  end

  // Register 0 is hard-wired; a same-cycle writeback to the read register wins.
  always_comb begin
    rs1_val = rf_reg[bus.Rs1];
    rs2_val = rf_reg[bus.Rs2];
    if (bus.Rs1 == 5'd0)
      rs1_val = '0;
    else if (bus.wb_en && bus.wb_rd == bus.Rs1)
      rs1_val = bus.wb_data;
    if (bus.Rs2 == 5'd0)
      rs2_val = '0;
    else if (bus.wb_en && bus.wb_rd == bus.Rs2)
      rs2_val = bus.wb_data;
  end

  assign imm_ext = (bus.OPcode == OP_IALU && bus.ALUop[2]) ? {16'h0000, bus.Imm}
                                                           : {{16{bus.Imm[15]}}, bus.Imm};

  assign hazard = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                  ((use_rs1 && bus.Rs1 == bus.ex_rd) || (use_rs2 && bus.Rs2 == bus.ex_rd));
  // Flush outranks the hazard: the squashed instruction needs no stall.
  assign stall     = !rst && !bus.flush && hazard;
  assign bubble    = bus.flush || stall;
  assign bus.stall = stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_reg[i] <= '0;
    end else if (bus.wb_en && bus.wb_rd != 5'd0) begin
      rf_reg[bus.wb_rd] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      bus.d_valid     <= 1'b0;
      bus.d_reg_write <= 1'b0;
      bus.d_mem_read  <= 1'b0;
      bus.d_mem_write <= 1'b0;
      bus.d_branch_eq <= 1'b0;
      bus.d_branch_ne <= 1'b0;
      bus.d_jump      <= 1'b0;
      bus.d_jump_reg  <= 1'b0;
      bus.d_illegal   <= 1'b0;
      bus.d_opcode    <= '0;
      bus.d_aluop     <= '0;
      bus.d_rs1       <= '0;
      bus.d_rs2       <= '0;
      bus.d_rd        <= '0;
      bus.d_rs1_val   <= '0;
      bus.d_rs2_val   <= '0;
      bus.d_imm       <= '0;
      bus.d_address   <= '0;
    end else begin
      bus.d_valid     <= 1'b1;
      bus.d_reg_write <= reg_write;
      bus.d_mem_read  <= mem_read;
      bus.d_mem_write <= mem_write;
      bus.d_branch_eq <= branch_eq;
      bus.d_branch_ne <= branch_ne;
      bus.d_jump      <= jump;
      bus.d_jump_reg  <= jump_reg;
      bus.d_illegal   <= illegal;
      bus.d_opcode    <= bus.OPcode;
      bus.d_aluop     <= bus.ALUop;
      bus.d_rs1       <= bus.Rs1;
      bus.d_rs2       <= bus.Rs2;
      bus.d_rd        <= bus.Rd;
      bus.d_rs1_val   <= rs1_val;
      bus.d_rs2_val   <= rs2_val;
      bus.d_imm       <= imm_ext;
      bus.d_address   <= bus.Address;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      bus.stall_count <= '0;
    else if (stall && bus.stall_count != 16'hFFFF)
      bus.stall_count <= bus.stall_count + 16'd1;
  end
endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: directed vector table, hand sequences
// and randomized traffic against a spec-level reference model.
module tb_instr_decode;
  logic clk = 1'b0;
  logic rst;
  instr_decode_if bus ();

  instr_decode dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic [4:0]  op;
    logic [2:0]  aluop;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [26:0] addr;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_mr;
    logic [4:0]  ex_rd;
  } vec_t;

  typedef struct packed {
    vec_t        v;
    logic        exp_stall;
    logic [8:0]  exp_ctrl;
    logic [31:0] exp_imm;
    logic [31:0] exp_rs1v;
    logic [15:0] exp_cnt;
  } tv_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mreg [32];
  int unsigned mcnt;
  tv_t tq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic fl, input logic [4:0] op,
                              input logic [2:0] aluop, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [15:0] imm,
                              input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                              input logic emr, input logic [4:0] erd);
    vec_t v;
    v.rst = r; v.flush = fl; v.op = op; v.aluop = aluop; v.rs1 = rs1; v.rs2 = rs2;
    v.rd = 5'd17; v.imm = imm; v.addr = 27'h4ABCDEF; v.wb_en = we; v.wb_rd = wrd;
    v.wb_data = wd; v.ex_mr = emr; v.ex_rd = erd;
    return v;
  endfunction

  // Reference model: decode rules straight from the opcode table.
  function automatic logic m_stall(input vec_t v);
    logic u1, u2;
    u1 = v.op inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8};
    u2 = v.op inside {5'd1, 5'd4, 5'd5, 5'd6};
    return !v.rst && !v.flush && v.ex_mr && v.ex_rd != 0 &&
           ((u1 && v.rs1 == v.ex_rd) || (u2 && v.rs2 == v.ex_rd));
  endfunction

  function automatic logic [8:0] m_ctrl(input logic [4:0] op);
    case (op)
      5'd0:       return 9'b1_0000_0000;
      5'd1, 5'd2: return 9'b1_1000_0000;
      5'd3:       return 9'b1_1100_0000;
      5'd4:       return 9'b1_0010_0000;
      5'd5:       return 9'b1_0001_0000;
      5'd6:       return 9'b1_0000_1000;
      5'd7:       return 9'b1_0000_0100;
      5'd8:       return 9'b1_0000_0010;
      default:    return 9'b1_0000_0001;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input vec_t v, input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (v.wb_en && v.wb_rd == r) return v.wb_data;
    return mreg[r];
  endfunction

  function automatic logic [31:0] m_imm(input vec_t v);
    if (v.op == 5'd2 && v.aluop[2]) return 32'(v.imm);
    return 32'($signed(v.imm));
  endfunction

  task automatic run(input vec_t v, output logic a_stall, output logic [8:0] a_ctrl,
                     output logic [31:0] a_imm, output logic [31:0] a_rs1v,
                     output logic [15:0] a_cnt);
    logic es, bub;
    logic [8:0] ec;
    logic [31:0] e_r1, e_r2, e_im;
    rst = v.rst; bus.flush = v.flush; bus.OPcode = v.op; bus.ALUop = v.aluop;
    bus.Rs1 = v.rs1; bus.Rs2 = v.rs2; bus.Rd = v.rd; bus.Imm = v.imm; bus.Address = v.addr;
    bus.wb_en = v.wb_en; bus.wb_rd = v.wb_rd; bus.wb_data = v.wb_data;
    bus.ex_mem_read = v.ex_mr; bus.ex_rd = v.ex_rd;
    #1;
    es = m_stall(v);
    a_stall = bus.stall;
    chk("stall", 32'(bus.stall), 32'(es));
    bub  = v.rst || v.flush || es;
    ec   = bub ? 9'd0 : m_ctrl(v.op);
    e_r1 = bub ? 32'd0 : m_read(v, v.rs1);
    e_r2 = bub ? 32'd0 : m_read(v, v.rs2);
    e_im = bub ? 32'd0 : m_imm(v);
    if (v.rst) begin
      for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
      mcnt = 0;
    end else begin
      if (v.wb_en && v.wb_rd != 0) mreg[v.wb_rd] = v.wb_data;
      if (es && mcnt < 65535) mcnt++;
    end
    @(posedge clk);
    #1;
    a_ctrl = {bus.d_valid, bus.d_reg_write, bus.d_mem_read, bus.d_mem_write, bus.d_branch_eq,
              bus.d_branch_ne, bus.d_jump, bus.d_jump_reg, bus.d_illegal};
    a_imm = bus.d_imm; a_rs1v = bus.d_rs1_val; a_cnt = bus.stall_count;
    chk("ctrl", 32'(a_ctrl), 32'(ec));
    chk("opcode", 32'(bus.d_opcode), bub ? 32'd0 : 32'(v.op));
    chk("aluop", 32'(bus.d_aluop), bub ? 32'd0 : 32'(v.aluop));
    chk("rs1", 32'(bus.d_rs1), bub ? 32'd0 : 32'(v.rs1));
    chk("rs2", 32'(bus.d_rs2), bub ? 32'd0 : 32'(v.rs2));
    chk("rd", 32'(bus.d_rd), bub ? 32'd0 : 32'(v.rd));
    chk("rs1_val", a_rs1v, e_r1);
    chk("rs2_val", bus.d_rs2_val, e_r2);
    chk("imm", a_imm, e_im);
    chk("address", 32'(bus.d_address), bub ? 32'd0 : 32'(v.addr));
    chk("stall_count", 32'(a_cnt), mcnt);
  endtask

  task automatic add(input vec_t v, input logic s, input logic [8:0] c,
                     input logic [31:0] im, input logic [31:0] r1, input logic [15:0] cnt);
    tq.push_back('{v, s, c, im, r1, cnt});
  endtask

  initial begin
    logic s;
    logic [8:0] c;
    logic [31:0] im, r1;
    logic [15:0] cnt;
    vec_t v;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    mcnt = 0;

    //  rst fl op    alu rs1 rs2 imm        we rd wdata          emr erd   stall ctrl          imm            rs1v           cnt
    add(mk(1,0,5'd1,3'd0,5'd7,5'd0,16'h0000,1,5'd3,32'd99,1,5'd7),        0, 9'b0_0000_0000, 32'h0,        32'h0,        16'd0);
    add(mk(1,0,5'd1,3'd0,5'd7,5'd0,16'h0000,1,5'd3,32'd99,1,5'd7),        0, 9'b0_0000_0000, 32'h0,        32'h0,        16'd0);
    add(mk(0,0,5'd1,3'd0,5'd3,5'd0,16'h0000,0,5'd0,32'd0,0,5'd0),         0, 9'b1_1000_0000, 32'h0,        32'h0,        16'd0);
    add(mk(0,0,5'd1,3'd0,5'd5,5'd0,16'h0000,1,5'd5,32'hDEADBEEF,0,5'd0),  0, 9'b1_1000_0000, 32'h0,        32'hDEADBEEF, 16'd0);
    add(mk(0,0,5'd2,3'd4,5'd5,5'd0,16'h8001,0,5'd0,32'd0,0,5'd0),         0, 9'b1_1000_0000, 32'h00008001, 32'hDEADBEEF, 16'd0);
    add(mk(0,0,5'd3,3'd0,5'd0,5'd0,16'h8001,0,5'd0,32'd0,0,5'd0),         0, 9'b1_1100_0000, 32'hFFFF8001, 32'h0,        16'd0);
    add(mk(0,0,5'd2,3'd3,5'd0,5'd0,16'h8001,0,5'd0,32'd0,0,5'd0),         0, 9'b1_1000_0000, 32'hFFFF8001, 32'h0,        16'd0);
    add(mk(0,0,5'd4,3'd0,5'd0,5'd7,16'h0010,0,5'd0,32'd0,1,5'd7),         1, 9'b0_0000_0000, 32'h0,        32'h0,        16'd1);
    add(mk(0,0,5'd4,3'd0,5'd0,5'd7,16'h0010,0,5'd0,32'd0,0,5'd0),         0, 9'b1_0010_0000, 32'h00000010, 32'h0,        16'd1);
    add(mk(0,0,5'd7,3'd0,5'd7,5'd7,16'h0000,0,5'd0,32'd0,1,5'd7),         0, 9'b1_0000_0100, 32'h0,        32'h0,        16'd1);
    add(mk(0,1,5'd1,3'd0,5'd7,5'd0,16'h0000,0,5'd0,32'd0,1,5'd7),         0, 9'b0_0000_0000, 32'h0,        32'h0,        16'd1);
    add(mk(0,0,5'd1,3'd0,5'd0,5'd0,16'h0000,0,5'd0,32'd0,1,5'd0),         0, 9'b1_1000_0000, 32'h0,        32'h0,        16'd1);
    add(mk(0,0,5'd0,3'd0,5'd0,5'd0,16'h0000,1,5'd0,32'd5,0,5'd0),         0, 9'b1_0000_0000, 32'h0,        32'h0,        16'd1);
    add(mk(0,0,5'd1,3'd0,5'd0,5'd0,16'h0000,0,5'd0,32'd0,0,5'd0),         0, 9'b1_1000_0000, 32'h0,        32'h0,        16'd1);
    add(mk(0,0,5'd31,3'd0,5'd0,5'd0,16'h0000,0,5'd0,32'd0,0,5'd0),        0, 9'b1_0000_0001, 32'h0,        32'h0,        16'd1);
    add(mk(0,0,5'd8,3'd0,5'd5,5'd0,16'h0000,0,5'd0,32'd0,1,5'd5),         1, 9'b0_0000_0000, 32'h0,        32'h0,        16'd2);
    add(mk(0,0,5'd8,3'd0,5'd5,5'd0,16'h0000,0,5'd0,32'd0,0,5'd0),         0, 9'b1_0000_0010, 32'h0,        32'hDEADBEEF, 16'd2);
    add(mk(0,0,5'd5,3'd0,5'd1,5'd9,16'h0000,0,5'd0,32'd0,1,5'd9),         1, 9'b0_0000_0000, 32'h0,        32'h0,        16'd3);
    add(mk(0,0,5'd6,3'd0,5'd9,5'd2,16'h0000,0,5'd0,32'd0,1,5'd9),         1, 9'b0_0000_0000, 32'h0,        32'h0,        16'd4);
    add(mk(0,0,5'd2,3'd0,5'd1,5'd9,16'h0000,0,5'd0,32'd0,1,5'd9),         0, 9'b1_1000_0000, 32'h0,        32'h0,        16'd4);
    add(mk(0,0,5'd3,3'd0,5'd4,5'd0,16'h0000,1,5'd4,32'h1234,1,5'd4),      1, 9'b0_0000_0000, 32'h0,        32'h0,        16'd5);
    add(mk(0,0,5'd3,3'd0,5'd4,5'd0,16'h0000,0,5'd0,32'd0,0,5'd0),         0, 9'b1_1100_0000, 32'h0,        32'h1234,     16'd5);
    add(mk(0,0,5'd5,3'd0,5'd4,5'd5,16'h0000,0,5'd0,32'd0,0,5'd0),         0, 9'b1_0001_0000, 32'h0,        32'h1234,     16'd5);
    add(mk(0,0,5'd4,3'd0,5'd0,5'd7,16'h0010,0,5'd0,32'd0,1,5'd7),         1, 9'b0_0000_0000, 32'h0,        32'h0,        16'd6);
    add(mk(1,0,5'd4,3'd0,5'd0,5'd7,16'h0010,0,5'd0,32'd0,1,5'd7),         0, 9'b0_0000_0000, 32'h0,        32'h0,        16'd0);
    add(mk(0,0,5'd4,3'd0,5'd0,5'd7,16'h0010,0,5'd0,32'd0,0,5'd0),         0, 9'b1_0010_0000, 32'h00000010, 32'h0,        16'd0);

    foreach (tq[i]) begin
      run(tq[i].v, s, c, im, r1, cnt);
      chk($sformatf("tv%0d_stall", i), 32'(s), 32'(tq[i].exp_stall));
      chk($sformatf("tv%0d_ctrl", i), 32'(c), 32'(tq[i].exp_ctrl));
      chk($sformatf("tv%0d_imm", i), im, tq[i].exp_imm);
      chk($sformatf("tv%0d_rs1v", i), r1, tq[i].exp_rs1v);
      chk($sformatf("tv%0d_cnt", i), 32'(cnt), 32'(tq[i].exp_cnt));
      $display("vector %0d op=%0d stall=%0d ctrl=%b imm=%h rs1v=%h cnt=%0d",
               i, tq[i].v.op, s, c, im, r1, cnt);
    end

    // Fill every register, reset, then confirm the whole file reads back zero.
    for (int i = 1; i < 32; i++)
      run(mk(0,0,5'd0,3'd0,5'd0,5'd0,16'h0,1,5'(i),32'h01010101 * 32'(i),0,5'd0), s, c, im, r1, cnt);
    run(mk(0,0,5'd4,3'd0,5'd3,5'd3,16'h0,0,5'd0,32'd0,1,5'd3), s, c, im, r1, cnt);
    run(mk(1,0,5'd1,3'd0,5'd3,5'd3,16'h0,0,5'd0,32'd0,0,5'd0), s, c, im, r1, cnt);
    chk("rst_ctrl", 32'(c), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    $display("reset pulse: ctrl=%b cnt=%0d", c, cnt);
    for (int i = 1; i < 32; i++) begin
      run(mk(0,0,5'd1,3'd0,5'(i),5'(i),16'h0,0,5'd0,32'd0,0,5'd0), s, c, im, r1, cnt);
      chk($sformatf("rf_clear_r%0d", i), r1, 32'd0);
      $display("read r%0d after reset: %h", i, r1);
    end

    for (int n = 0; n < 400; n++) begin
      int unsigned k;
      k = $urandom_range(0, 11);
      v.rst = ($urandom_range(0, 49) == 0);
      v.flush = ($urandom_range(0, 7) == 0);
      v.op = (k <= 8) ? 5'(k) : 5'($urandom_range(9, 31));
      v.aluop = 3'($urandom);
      v.rs1 = 5'($urandom_range(0, 7));
      v.rs2 = 5'($urandom_range(0, 7));
      v.rd = 5'($urandom);
      v.imm = 16'($urandom);
      v.addr = 27'($urandom);
      v.wb_en = 1'($urandom);
      v.wb_rd = 5'($urandom_range(0, 9));
      v.wb_data = $urandom;
      v.ex_mr = ($urandom_range(0, 2) == 0);
      v.ex_rd = 5'($urandom_range(0, 7));
      run(v, s, c, im, r1, cnt);
      $display("random %0d op=%0d rst=%0d flush=%0d stall=%0d ctrl=%b cnt=%0d",
               n, v.op, v.rst, v.flush, s, c, cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
